// File: rtl/tim_pkg.sv
// Shared definitions for the APB timer bank: register map, CTRL bit positions
// and the channel FSM state type.
package tim_pkg;

  localparam logic [7:0] CH_STRIDE = 8'h14;

  localparam logic [7:0] OFF_LOAD = 8'h00;
  localparam logic [7:0] OFF_CUR  = 8'h04;
  localparam logic [7:0] OFF_CTRL = 8'h08;
  localparam logic [7:0] OFF_EOI  = 8'h0C;
  localparam logic [7:0] OFF_STAT = 8'h10;

  localparam logic [7:0] ADDR_INTS   = 8'hA0;
  localparam logic [7:0] ADDR_EOIALL = 8'hA4;
  localparam logic [7:0] ADDR_RAWS   = 8'hA8;
  localparam logic [7:0] ADDR_PSC    = 8'hAC;
  localparam logic [7:0] ADDR_TRIGEN = 8'hB0;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_MASK     = 2;
  localparam int CTRL_ONESHOT  = 3;
  localparam int CTRL_W        = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_e;

  // Byte address (low 8 bits) of register 'off' in channel 'ch'.
  function automatic logic [7:0] chan_addr(input int ch, input logic [7:0] off);
    return 8'(ch * int'(CH_STRIDE) + int'(off));
  endfunction

endpackage

// File: rtl/tim_nch_chan.sv
// One timer channel: IDLE/RUN FSM, down-counter, interrupt status and the
// ETB trigger enable with its one-cycle expiry pulse.
module tim_nch_chan
  import tim_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              tick,
  input  logic              load_we,
  input  logic              ctrl_we,
  input  logic [31:0]       wdata,
  input  logic              eoi_clr,
  input  logic              trig_on,
  input  logic              trig_off,
  output logic [CNT_W-1:0]  load,
  output logic [CNT_W-1:0]  cur,
  output logic [CTRL_W-1:0] ctrl,
  output logic              int_stat,
  output logic              trig_en,
  output logic              etb_trig
);

  chan_state_e state;
  logic        load_pend;  // RUN just entered: CUR picks up LOAD next cycle
  logic        running;
  logic        expiry;
  logic        start_wr;
  logic        stop_wr;

  assign running  = (state == RUN) && !load_pend;
  assign expiry   = running && tick && (cur == '0);
  assign start_wr = ctrl_we && wdata[CTRL_EN] && (state == IDLE);
  assign stop_wr  = ctrl_we && !wdata[CTRL_EN];

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      load_pend <= 1'b0;
      load      <= '0;
      cur       <= '1;
      ctrl      <= '0;
      int_stat  <= 1'b0;
      trig_en   <= 1'b0;
      etb_trig  <= 1'b0;
    end else begin
      etb_trig <= expiry && trig_en;

      if (trig_off)     trig_en <= 1'b0;
      else if (trig_on) trig_en <= 1'b1;

      // Expiry beats an end-of-interrupt read in the same cycle.
      if (expiry)       int_stat <= 1'b1;
      else if (eoi_clr) int_stat <= 1'b0;

      if (load_we) load <= wdata[CNT_W-1:0];
      if (ctrl_we) ctrl <= wdata[CTRL_W-1:0];

      if (expiry && ctrl[CTRL_ONESHOT]) begin
        state          <= IDLE;
        load_pend      <= 1'b0;
        cur            <= '0;
        ctrl[CTRL_EN]  <= 1'b0;
      end else if (stop_wr) begin
        state     <= IDLE;
        load_pend <= 1'b0;
      end else if (start_wr) begin
        state     <= RUN;
        load_pend <= 1'b1;
      end else if (state == RUN) begin
        if (load_pend) begin
          cur       <= load;
          load_pend <= 1'b0;
        end else if (expiry) begin
          cur <= ctrl[CTRL_PERIODIC] ? load : '1;
        end else if (tick) begin
          cur <= cur - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tim_nch_apb_top.sv
// APB timer bank: NCH down-counter channels behind one shared prescaler, with
// APB decode, read mux and EOIALL fan-out.
module tim_nch_apb_top
  import tim_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 32,
  parameter int PSC_W = 8
) (
  input  logic           pclk,
  input  logic           presetn,
  input  logic           psel,
  input  logic           penable,
  input  logic           pwrite,
  input  logic [31:0]    paddr,
  input  logic [31:0]    pwdata,
  output logic [31:0]    prdata,
  input  logic           scan_mode,
  input  logic [NCH-1:0] etb_trig_en_on,
  input  logic [NCH-1:0] etb_trig_en_off,
  output logic [NCH-1:0] intr,
  output logic [NCH-1:0] etb_trig
);

  logic [7:0]        addr;
  logic              wr_en;
  logic              rd_en;
  logic              eoiall_rd;
  logic [PSC_W-1:0]  psc;
  logic [PSC_W-1:0]  psc_cnt;
  logic              tick;
  logic              any_en;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    ch_mask;
  logic [NCH-1:0]    int_stat;
  logic [NCH-1:0]    trig_en;
  logic [NCH-1:0]    load_we;
  logic [NCH-1:0]    ctrl_we;
  logic [NCH-1:0]    eoi_clr;
  logic [CNT_W-1:0]  ch_load [NCH];
  logic [CNT_W-1:0]  ch_cur  [NCH];
  logic [CTRL_W-1:0] ch_ctrl [NCH];
  logic              unused_ok;

  assign addr      = paddr[7:0];
  assign wr_en     = psel & penable & pwrite;
  assign rd_en     = psel & penable & ~pwrite;
  assign eoiall_rd = rd_en && (addr == ADDR_EOIALL);
  assign unused_ok = ^{scan_mode, paddr[31:8], pwdata};

  assign any_en = |ch_en;
  assign tick   = (psc_cnt == psc);
  assign intr   = int_stat & ~ch_mask;

  // Restart on >= so a PSC shrunk below the running count never wraps the full range.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psc     <= '0;
      psc_cnt <= '0;
    end else begin
      if (wr_en && (addr == ADDR_PSC)) psc <= pwdata[PSC_W-1:0];
      if (!any_en || (psc_cnt >= psc)) psc_cnt <= '0;
      else                             psc_cnt <= psc_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign load_we[i] = wr_en && (addr == chan_addr(i, OFF_LOAD));
    assign ctrl_we[i] = wr_en && (addr == chan_addr(i, OFF_CTRL));
    assign eoi_clr[i] = eoiall_rd || (rd_en && (addr == chan_addr(i, OFF_EOI)));
    assign ch_en[i]   = ch_ctrl[i][CTRL_EN];
    assign ch_mask[i] = ch_ctrl[i][CTRL_MASK];

    tim_nch_chan #(.CNT_W(CNT_W)) u_chan (
      .pclk     (pclk),
      .presetn  (presetn),
      .tick     (tick),
      .load_we  (load_we[i]),
      .ctrl_we  (ctrl_we[i]),
      .wdata    (pwdata),
      .eoi_clr  (eoi_clr[i]),
      .trig_on  (etb_trig_en_on[i]),
      .trig_off (etb_trig_en_off[i]),
      .load     (ch_load[i]),
      .cur      (ch_cur[i]),
      .ctrl     (ch_ctrl[i]),
      .int_stat (int_stat[i]),
      .trig_en  (trig_en[i]),
      .etb_trig (etb_trig[i])
    );
  end

  always_comb begin
    // NOTE: default assigned first so every path drives prdata and no latch is inferred.
    prdata = '0;
    if (psel && !pwrite) begin
      for (int i = 0; i < NCH; i++) begin
        if (addr == chan_addr(i, OFF_LOAD)) prdata = 32'(ch_load[i]);
        if (addr == chan_addr(i, OFF_CUR))  prdata = 32'(ch_cur[i]);
        if (addr == chan_addr(i, OFF_CTRL)) prdata = 32'(ch_ctrl[i]);
        if (addr == chan_addr(i, OFF_STAT)) prdata = 32'(int_stat[i]);
      end
      case (addr)
        ADDR_INTS:   prdata = 32'(intr);
        ADDR_RAWS:   prdata = 32'(int_stat);
        ADDR_PSC:    prdata = 32'(psc);
        ADDR_TRIGEN: prdata = 32'(trig_en);
        default:     ;
      endcase
    end
  end

endmodule
